uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  - 8N1 UART serial transmitter, the companion to the uart_rx receiver in the same link.
//  - Accepts one byte per valid/ready handshake and shifts it out on o_tx, LSB first.
//  - Each bit is held for CLK_PER_BIT clocks.
//  - Sits between the core logic and the board TX pin.
// PARAMETERS
//  CLK_FREQ     50000000  system clock in Hz (documentation only)
//  BAUD_RATE    9600      line rate in baud (documentation only)
//  CLK_PER_BIT  5208      clocks per bit = CLK_FREQ/BAUD_RATE; legal range 2..8191
//  STOP_BITS    1         number of stop bits, 1 or 2
// PORTS
//  i_clk        in   1  system clock, rising edge
//  i_reset      in   1  asynchronous, active-high reset
//  i_data_in    in   8  byte to send; sampled only on handshake
//  i_valid_in   in   1  byte on i_data_in is valid
//  o_ready      out  1  high in IDLE; handshake = i_valid_in & o_ready at a rising edge
//  o_tx         out  1  serial line; idle high; registered output
//  o_busy       out  1  high while a frame is in progress (state != IDLE)
//  o_done       out  1  one-cycle pulse on the cycle after the last stop bit ends
// BEHAVIOUR
//  - Reset values: o_tx=1, o_ready=1, o_busy=0, o_done=0; state=IDLE; counters=0; shift reg=0.
//    Reset acts immediately (asynchronous), including mid-frame: the line goes high at once and the frame is dropped.
//  - States and transitions:
//    IDLE  -> START   on handshake
//    START -> DATA    after CLK_PER_BIT clocks
//    DATA  -> (PARITY) -> STOP   after 8 bits
//    STOP  -> IDLE    after STOP_BITS*CLK_PER_BIT clocks
//  - Handshake edge: latch i_data_in into the shift reg; o_tx<=0 (start bit) and o_ready<=0 take effect on the next cycle.
//  - Bit timer counts 0..CLK_PER_BIT-1; the bit ends when the count reaches CLK_PER_BIT-1, then the timer wraps to 0.
//  - DATA: bit index 0..7; o_tx = shift[0]; shift right at each bit end; leaves DATA when index 7 ends.
//  - STOP: o_tx=1. On exit, state=IDLE, o_ready=1, o_done=1 for exactly one cycle, o_busy=0.
//  - Back-to-back frames: a handshake in the o_done cycle is accepted.
//    The line then has exactly one idle-high clock between the last stop bit and the next start bit.
//  - i_valid_in while o_ready=0 is ignored and not queued. i_data_in changes mid-frame have no effect.
//  - Frame length, handshake to return to IDLE: (10 + STOP_BITS - 1 [+1 parity]) * CLK_PER_BIT clocks.
//  - Timer width is $clog2(CLK_PER_BIT). CLK_PER_BIT outside 2..8191 is a configuration error (elaboration check).
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN:
//    - Defined: a PARITY state follows DATA and sends one bit for CLK_PER_BIT clocks.
//    - The parity bit is the XOR of the 8 data bits (even parity); the frame is 11 + STOP_BITS - 1 bits long.
//    - Not defined: no PARITY state, plain 8N1/8N2 framing, and no parity logic is synthesised.
// STRUCTURE
//  - Package uart_pkg:
//    - state encodings ST_IDLE=0, ST_START=1, ST_DATA=2, ST_STOP=3, ST_PARITY=4 (3-bit state);
//    - UART_DATA_W=8;
//    - function clk_per_bit(clk_freq, baud).
//  - Sub-module uart_baud_tick: counter with enable and synchronous clear.
//    Emits a one-cycle tick at count CLK_PER_BIT-1. Reusable by uart_rx.
//  - uart_tx holds the FSM, shift register, bit index and output registers.
// TESTING (bench uses CLK_PER_BIT=16, STOP_BITS=1 unless stated)
//  1. Send 0xA5 -> o_tx = 0 for 16 clocks, then bits 1,0,1,0,0,1,0,1 (16 clocks each), then 1 for 16 clocks.
//     o_done pulses once; o_ready is low for exactly 160 clocks.
//  2. Hold i_valid_in with 0x00 then 0xFF back-to-back -> two frames separated by exactly 1 idle-high clock.
//     A uart_rx loopback receives 0x00 then 0xFF.
//  3. Pulse i_valid_in with 0x3C at frame clock 40 of a 0x55 frame -> 0x3C is not sent.
//     o_tx stays idle after the 0x55 frame.
//  4. Assert i_reset at clock 70 of a 0x81 frame -> o_tx=1 within the same cycle and all outputs at reset values.
//     A new 0x81 sent after reset completes correctly.
//  5. Set STOP_BITS=2 and send 0x0F -> stop high for 32 clocks; o_done 176 clocks after the handshake.
//  6. Define UART_TX_PARITY_EN and send 0x07 (three ones) -> parity bit 1 after bit 7.
//     Send 0x03 -> parity bit 0. Frame = 176 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, widths and helpers for the uart_tx / uart_rx pair.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_e;

    function automatic int unsigned clk_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between core logic (master) and the UART transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] data_in;
    logic                   valid_in;
    logic                   ready;

    modport master (
        output data_in,
        output valid_in,
        input  ready
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_tick #(
    parameter  int unsigned CLK_PER_BIT = 5208,
    localparam int unsigned CNT_W       = $clog2(CLK_PER_BIT)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 8191) begin : g_bad_cpb
        $error("uart_baud_tick: CLK_PER_BIT must be in 2..8191");
    end

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tick = i_en & ~i_clear & (count_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter, LSB first, registered line output.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_tx_if.slave bus,
    output logic     o_tx,
    output logic     o_busy,
    output logic     o_done
);

    localparam logic [2:0] LAST_BIT  = 3'd7;
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 8191) begin : g_bad_cpb
        $error("uart_tx: CLK_PER_BIT must be in 2..8191");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   handshake;
    logic                   tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign handshake = bus.valid_in & ready_q;

    uart_baud_tick #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (state_q != ST_IDLE),
        .i_clear (state_q == ST_IDLE),
        .o_tick  (tick)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (handshake) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick && bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP:  if (tick && bit_idx_q == STOP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: bit_idx counts data bits in DATA and stop bits in STOP, restarting on each state change
    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q == ST_IDLE) begin
            if (handshake) begin
                shift_d   = bus.data_in;
                bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^bus.data_in;
`endif
            end
        end else if (tick) begin
            if (state_q == ST_DATA) begin
                shift_d = shift_q >> 1;
            end
            bit_idx_d = (state_d != state_q) ? 3'd0 : bit_idx_q + 3'd1;
        end
    end

    // Output logic, decoded from the next state so every output is a flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign bus.ready = ready_q;
    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one-stop and two-stop instances, behavioural loopback receiver.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       i_clk    = 1'b0;
    logic       i_reset  = 1'b1;
    logic       valid_tb = 1'b0;
    logic [7:0] data_tb  = 8'h00;
    logic       sel      = 1'b0;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];

    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    assign bus1.valid_in = valid_tb & ~sel;
    assign bus1.data_in  = data_tb;
    assign bus2.valid_in = valid_tb & sel;
    assign bus2.data_in  = data_tb;

    uart_tx #(
        .CLK_FREQ    (50000000),
        .BAUD_RATE   (9600),
        .CLK_PER_BIT (CPB),
        .STOP_BITS   (1)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus1),
        .o_tx    (tx1),
        .o_busy  (busy1),
        .o_done  (done1)
    );

    uart_tx #(
        .CLK_FREQ    (50000000),
        .BAUD_RATE   (9600),
        .CLK_PER_BIT (CPB),
        .STOP_BITS   (2)
    ) dut2 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus2),
        .o_tx    (tx2),
        .o_busy  (busy2),
        .o_done  (done2)
    );

    wire m_tx    = sel ? tx2 : tx1;
    wire m_ready = sel ? bus2.ready : bus1.ready;
    wire m_busy  = sel ? busy2 : busy1;
    wire m_done  = sel ? done2 : done1;

    always #5 i_clk = ~i_clk;

    // Loopback receiver on the one-stop instance: samples mid-bit
    always begin
        logic [7:0] b;
        @(negedge tx1);
        repeat (CPB / 2) @(posedge i_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge i_clk);
            #1;
            b[i] = tx1;
        end
        repeat (CPB * (1 + PAR)) @(posedge i_clk);
        #1;
        rx_q.push_back(b);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        valid_tb = 1'b1;
        data_tb  = d;
        step();
        valid_tb = 1'b0;
    endtask

    // Entered on cycle 1 after the handshake edge; leaves on the cycle after the last stop bit.
    task automatic frame_check(input string tag, input logic [7:0] d, input int stops,
                               input int poke_at, input logic [7:0] poke_d);
        logic [11:0] exp_bits;
        int          nb, rl, dn, n;
        logic        ok;
        nb            = 10 + stops - 1 + PAR;
        exp_bits      = '1;
        exp_bits[0]   = 1'b0;
        exp_bits[8:1] = d;
        if (PAR != 0) exp_bits[9] = ^d;
        rl = 0;
        dn = 0;
        n  = 1;
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1;
            for (int c = 0; c < int'(CPB); c++) begin
                if (n == poke_at) begin
                    valid_tb = 1'b1;
                    data_tb  = poke_d;
                end else if (poke_at >= 0 && n == poke_at + 1) begin
                    valid_tb = 1'b0;
                end
                if (m_tx !== exp_bits[b]) ok = 1'b0;
                if (m_ready === 1'b0) rl++;
                if (m_done !== 1'b0) dn++;
                step();
                n++;
            end
            chk($sformatf("%s bit%0d", tag, b), 32'(ok), 32'd1);
        end
        chk({tag, " ready_low"}, rl, nb * CPB);
        chk({tag, " early_done"}, dn, 0);
        chk({tag, " done"}, 32'(m_done), 32'd1);
        chk({tag, " ready"}, 32'(m_ready), 32'd1);
        chk({tag, " idle_tx"}, 32'(m_tx), 32'd1);
        chk({tag, " busy"}, 32'(m_busy), 32'd0);
    endtask

    initial begin
        int bad;
        logic [7:0] r0, r1;

        step();
        step();
        chk("rst tx", 32'(tx1), 32'd1);
        chk("rst ready", 32'(bus1.ready), 32'd1);
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst done", 32'(done1), 32'd0);
        i_reset = 1'b0;
        step();

        // 1: single 0xA5 frame
        rx_q.delete();
        send(8'hA5);
        frame_check("t1", 8'hA5, 1, -1, 8'h00);
        step();
        chk("t1 done_pulse", 32'(done1), 32'd0);
        chk("t1 rx_cnt", rx_q.size(), 1);
        r0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        chk("t1 rx_byte", 32'(r0), 32'hA5);

        // 2: back-to-back with valid held high
        rx_q.delete();
        valid_tb = 1'b1;
        data_tb  = 8'h00;
        step();
        data_tb  = 8'hFF;
        frame_check("t2a", 8'h00, 1, -1, 8'h00);
        step();
        valid_tb = 1'b0;
        frame_check("t2b", 8'hFF, 1, -1, 8'h00);
        repeat (4) step();
        chk("t2 rx_cnt", rx_q.size(), 2);
        r0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        r1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
        chk("t2 rx0", 32'(r0), 32'h00);
        chk("t2 rx1", 32'(r1), 32'hFF);

        // 3: valid pulse mid-frame is dropped
        send(8'h55);
        frame_check("t3", 8'h55, 1, 40, 8'h3C);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            if (tx1 !== 1'b1 || bus1.ready !== 1'b1 || busy1 !== 1'b0) bad++;
            step();
        end
        chk("t3 stays_idle", bad, 0);

        // 4: asynchronous reset mid-frame
        send(8'h81);
        repeat (69) step();
        chk("t4 pre_rst_tx", 32'(tx1), 32'd0);
        i_reset = 1'b1;
        #1;
        chk("t4 rst_tx", 32'(tx1), 32'd1);
        chk("t4 rst_ready", 32'(bus1.ready), 32'd1);
        chk("t4 rst_busy", 32'(busy1), 32'd0);
        chk("t4 rst_done", 32'(done1), 32'd0);
        step();
        i_reset = 1'b0;
        step();
        send(8'h81);
        frame_check("t4", 8'h81, 1, -1, 8'h00);

        // 5: two stop bits
        sel = 1'b1;
        step();
        send(8'h0F);
        frame_check("t5", 8'h0F, 2, -1, 8'h00);
        step();
        sel = 1'b0;

`ifdef UART_TX_PARITY_EN
        // 6: even parity
        send(8'h07);
        frame_check("t6a", 8'h07, 1, -1, 8'h00);
        send(8'h03);
        frame_check("t6b", 8'h03, 1, -1, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
